// File: rtl/itcm_axi_rd_slave.sv
// AXI4 read-only slave serving IFU fetches from a one-cycle-latency ITCM SRAM.
// Define ITCM_RD_SKID_EN for a 2-entry R buffer (1 beat/clk); otherwise a single output register.
module itcm_axi_rd_slave #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ID_WIDTH       = 4,
    parameter int                    MEM_DEPTH_LOG2 = 14,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                S_AXI_ARLEN,
    input  logic [2:0]                S_AXI_ARSIZE,
    input  logic [1:0]                S_AXI_ARBURST,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [ID_WIDTH-1:0]       S_AXI_RID,
    output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RLAST,
    output logic [3:0]                S_AXI_RUSER,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic                      mem_req_o,
    output logic [MEM_DEPTH_LOG2-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

`ifdef ITCM_RD_SKID_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(1) << (MEM_DEPTH_LOG2 + 3);

    // IDLE: accept AR | BURST: issue beats to SRAM | DRAIN: wait for RLAST handshake
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [7:0]            len_q, beat_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;

    logic                  inf_vld, inf_err, inf_last;
    logic [1:0]            buf_cnt;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_err  [2];
    logic                  buf_last [2];

    logic                  ar_hs, ar_err, issue, beat_bad, oor, last_beat;
    logic [ADDR_WIDTH-1:0] off, inc, bnd_mask, ar_align;
    logic                  head_buf, pop, push, wr_idx, r_hs;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_err, head_last;

    assign S_AXI_ARREADY = (state == IDLE) && !rst;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    always_comb begin
        ar_align = (ADDR_WIDTH'(1) << S_AXI_ARSIZE) - ADDR_WIDTH'(1);
        ar_err   = (S_AXI_ARSIZE > 3'd3) || (S_AXI_ARBURST == 2'b11);
        if (S_AXI_ARBURST == 2'b10) begin
            if (!(S_AXI_ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}))
                ar_err = 1'b1;
            if ((S_AXI_ARADDR & ar_align) != '0)
                ar_err = 1'b1;
        end
    end

    assign off       = addr_q - BASE_ADDR;
    assign oor       = (addr_q < BASE_ADDR) || ({1'b0, off} >= MEM_BYTES);
    assign beat_bad  = err_q || oor;
    assign last_beat = (beat_q == len_q);
    // credit = free buffer entries minus the read already on its way back
    assign issue     = (state == BURST) && ((int'(buf_cnt) + int'(inf_vld)) < BUF_DEPTH);
    assign mem_req_o  = issue && !beat_bad;
    assign mem_addr_o = mem_req_o ? off[MEM_DEPTH_LOG2+2:3] : '0;

    always_comb begin
        inc      = ADDR_WIDTH'(1) << size_q;
        bnd_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) * inc) - ADDR_WIDTH'(1);
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~bnd_mask) | ((addr_q + inc) & bnd_mask);
            default: addr_nxt = addr_q + inc;
        endcase
    end

    // Head of the R channel: buffered beat first, else the SRAM beat arriving this cycle.
    assign head_buf  = (buf_cnt != 2'd0);
    assign head_data = head_buf ? buf_data[0] : (inf_err ? '0 : mem_rdata_i);
    assign head_err  = head_buf ? buf_err[0]  : inf_err;
    assign head_last = head_buf ? buf_last[0] : inf_last;

    assign S_AXI_RVALID = head_buf || inf_vld;
    assign S_AXI_RDATA  = S_AXI_RVALID ? head_data : '0;
    assign S_AXI_RRESP  = (S_AXI_RVALID && head_err) ? 2'b10 : 2'b00;
    assign S_AXI_RLAST  = S_AXI_RVALID && head_last;
    assign S_AXI_RID    = S_AXI_RVALID ? id_q : '0;
    assign S_AXI_RUSER  = '0;

    assign r_hs   = S_AXI_RVALID && S_AXI_RREADY;
    assign pop    = head_buf && S_AXI_RREADY;
    assign push   = inf_vld && !(!head_buf && S_AXI_RREADY);
    assign wr_idx = (buf_cnt == 2'd2) || ((buf_cnt == 2'd1) && !pop);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = BURST;
            BURST:   if (issue && last_beat) state_nxt = DRAIN;
            DRAIN:   if (r_hs && head_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            inf_vld  <= 1'b0;
            inf_err  <= 1'b0;
            inf_last <= 1'b0;
        end else begin
            state    <= state_nxt;
            inf_vld  <= issue;
            inf_err  <= beat_bad;
            inf_last <= last_beat;
            if (ar_hs) begin
                id_q    <= S_AXI_ARID;
                addr_q  <= S_AXI_ARADDR;
                len_q   <= S_AXI_ARLEN;
                size_q  <= S_AXI_ARSIZE;
                burst_q <= S_AXI_ARBURST;
                err_q   <= ar_err;
                beat_q  <= '0;
            end else if (issue) begin
                addr_q <= addr_nxt;
                beat_q <= beat_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_err[i]  <= 1'b0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_err[0]  <= buf_err[1];
                buf_last[0] <= buf_last[1];
            end
            if (push) begin
                buf_data[wr_idx] <= inf_err ? '0 : mem_rdata_i;
                buf_err[wr_idx]  <= inf_err;
                buf_last[wr_idx] <= inf_last;
            end
        end
    end

endmodule

// File: tb/tb_itcm_axi_rd_slave.sv
// Directed bench for itcm_axi_rd_slave with an SRAM model and R-channel collector.
module tb_itcm_axi_rd_slave;

`ifdef ITCM_RD_SKID_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  ruser;
    logic        rvalid;
    logic        rready;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic [63:0] sram_q = '0;

    int cyc = 0;
    int vecs = 0;
    int miscompares = 0;

    logic [63:0] got_data [16];
    logic [1:0]  got_resp [16];
    logic        got_last [16];
    logic [3:0]  got_id   [16];
    int          got_cyc  [16];
    int          t_ar, first_rv, first_req, reqs, n_got;
    logic [13:0] first_req_addr;

    itcm_axi_rd_slave dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_ARID    (arid),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RID     (rid),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RUSER   (ruser),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (sram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] memf(input logic [13:0] w);
        return {16'hC0DE, 2'b00, w, 2'b11, ~w, 16'h600D};
    endfunction

    always @(posedge clk) if (mem_req) sram_q <= memf(mem_addr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [63:0] data,
                            input logic [1:0] resp, input logic last, input logic [3:0] id);
        chk($sformatf("%s_data[%0d]", tag, i), got_data[i], data);
        chk($sformatf("%s_ctl[%0d]", tag, i), {57'd0, got_resp[i], got_last[i], got_id[i]},
            {57'd0, resp, last, id});
    endtask

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit rnd,
                             input int stop_after);
        int budget;
        int n;
        int want;
        logic stalled;
        logic [63:0] hd;
        logic [7:0] hc;
        n = 0; stalled = 1'b0; hd = '0; hc = '0;
        first_rv = -1; first_req = -1; reqs = 0; first_req_addr = '0;
        want = (stop_after < 0) ? int'(len) + 1 : stop_after;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        #1;
        budget = 0;
        while (!arready && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        chk("ar_accept", {63'd0, arready}, 64'd1);
        t_ar = cyc;
        budget = 0;
        while (n < want && budget < 300) begin
            @(negedge clk);
            arvalid = 1'b0;
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (mem_req) begin
                if (first_req < 0) begin
                    first_req = cyc;
                    first_req_addr = mem_addr;
                end
                reqs++;
            end
            if (stalled) begin
                chk("r_hold_data", rdata, hd);
                chk("r_hold_ctl", {56'd0, rvalid, rid, rresp, rlast}, {56'd0, hc});
            end
            stalled = 1'b0;
            if (rvalid) begin
                if (first_rv < 0) first_rv = cyc;
                if (rready) begin
                    got_data[n] = rdata; got_resp[n] = rresp; got_last[n] = rlast;
                    got_id[n] = rid; got_cyc[n] = cyc;
                    n++;
                end else begin
                    stalled = 1'b1;
                    hd = rdata;
                    hc = {rvalid, rid, rresp, rlast};
                end
            end
            budget++;
        end
        n_got = n;
        chk("beat_count", 64'(n), 64'(want));
    endtask

    initial begin
        rst = 1'b1; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctl", {48'd0, arready, rvalid, rlast, rid, rresp, ruser, mem_req},
            64'd0);
        chk("rst_addr_data", rdata | {50'd0, mem_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_arready", {63'd0, arready}, 64'd1);

        // single beat
        run_burst(4'd3, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0, -1);
        chk("t1_req_lat", 64'(first_req - t_ar), 64'd1);
        chk("t1_req_addr", {50'd0, first_req_addr}, 64'h20);
        chk("t1_rv_lat", 64'(first_rv - t_ar), 64'd2);
        chk_beat("t1", 0, memf(14'h20), 2'b00, 1'b1, 4'd3);

        // INCR len 7 from 0
        run_burst(4'd6, 32'h0, 8'd7, 3'd3, 2'b01, 1'b0, -1);
        chk("t2_rv_lat", 64'(first_rv - t_ar), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk_beat("t2", i, memf(14'(i)), 2'b00, i == 7, 4'd6);
            if (i > 0) chk($sformatf("t2_gap[%0d]", i), 64'(got_cyc[i] - got_cyc[i-1]), 64'(GAP));
        end

        // WRAP len 3 at 0x18 -> words 3,0,1,2
        run_burst(4'd1, 32'h18, 8'd3, 3'd3, 2'b10, 1'b0, -1);
        chk_beat("t3", 0, memf(14'd3), 2'b00, 1'b0, 4'd1);
        chk_beat("t3", 1, memf(14'd0), 2'b00, 1'b0, 4'd1);
        chk_beat("t3", 2, memf(14'd1), 2'b00, 1'b0, 4'd1);
        chk_beat("t3", 3, memf(14'd2), 2'b00, 1'b1, 4'd1);

        // WRAP len 2: illegal, all SLVERR, no SRAM reads
        run_burst(4'd2, 32'h0, 8'd2, 3'd3, 2'b10, 1'b0, -1);
        chk("t4_reqs", 64'(reqs), 64'd0);
        chk("t4_rv_lat", 64'(first_rv - t_ar), 64'd2);
        for (int i = 0; i < 3; i++) chk_beat("t4", i, 64'd0, 2'b10, i == 2, 4'd2);

        // INCR len 3 from last word: beat 0 OK, the rest out of range
        run_burst(4'd7, 32'h1FFF8, 8'd3, 3'd3, 2'b01, 1'b0, -1);
        chk("t5_reqs", 64'(reqs), 64'd1);
        chk_beat("t5", 0, memf(14'h3FFF), 2'b00, 1'b0, 4'd7);
        for (int i = 1; i < 4; i++) chk_beat("t5", i, 64'd0, 2'b10, i == 3, 4'd7);

        // FIXED len 2 at 0x28 -> word 5 three times
        run_burst(4'd4, 32'h28, 8'd2, 3'd3, 2'b00, 1'b0, -1);
        chk("t6_reqs", 64'(reqs), 64'd3);
        for (int i = 0; i < 3; i++) chk_beat("t6", i, memf(14'd5), 2'b00, i == 2, 4'd4);

        // ARSIZE 4 is illegal for a 64-bit bus
        run_burst(4'd8, 32'h0, 8'd0, 3'd4, 2'b01, 1'b0, -1);
        chk_beat("t7", 0, 64'd0, 2'b10, 1'b1, 4'd8);

        // narrow INCR: size 2 steps 4 bytes, full word returned
        run_burst(4'd10, 32'h44, 8'd1, 3'd2, 2'b01, 1'b0, -1);
        chk_beat("t8", 0, memf(14'd8), 2'b00, 1'b0, 4'd10);
        chk_beat("t8", 1, memf(14'd9), 2'b00, 1'b1, 4'd10);

        // len 15 with random RREADY back-pressure
        run_burst(4'd12, 32'h200, 8'd15, 3'd3, 2'b01, 1'b1, -1);
        for (int i = 0; i < 16; i++) chk_beat("t9", i, memf(14'(8'h40 + i)), 2'b00, i == 15, 4'd12);

        // reset mid-burst after beat 2
        run_burst(4'd5, 32'h0, 8'd7, 3'd3, 2'b01, 1'b0, 3);
        for (int i = 0; i < 3; i++) chk_beat("t10", i, memf(14'(i)), 2'b00, 1'b0, 4'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t10_rst_ctl", {48'd0, arready, rvalid, rlast, rid, rresp, ruser, mem_req}, 64'd0);
        chk("t10_rst_addr_data", rdata | {50'd0, mem_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_burst(4'd9, 32'h40, 8'd1, 3'd3, 2'b01, 1'b0, -1);
        chk("t10_rv_lat", 64'(first_rv - t_ar), 64'd2);
        chk_beat("t10b", 0, memf(14'd8), 2'b00, 1'b0, 4'd9);
        chk_beat("t10b", 1, memf(14'd9), 2'b00, 1'b1, 4'd9);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
